// File: rtl/rsa_modexp_engine_pkg.sv
// Shared constants for the RSA modular-exponentiation datapath: default width and
// controller state encodings.
package rsa_modexp_engine_pkg;

  localparam int BITS_DEF = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_SCAN  = 3'd2;
  localparam logic [2:0] ST_SQR   = 3'd3;
  localparam logic [2:0] ST_MUL   = 3'd4;
  localparam logic [2:0] ST_FIN   = 3'd5;

endpackage

// File: rtl/rsa_modmul.sv
// Interleaved shift-add modular multiplier p = a*b mod n, MSB first over a.
// One start cycle, BITS step cycles; done is high in the cycle the caller writes p back.
module rsa_modmul
  import rsa_modexp_engine_pkg::*;
#(
  parameter int BITS = BITS_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic [BITS-1:0] n,
  output logic [BITS-1:0] p,
  output logic            done
);

  localparam int W  = BITS + 2;
  localparam int KW = $clog2(BITS);
  localparam logic [KW-1:0] K_TOP  = KW'(BITS - 1);
  localparam logic [KW-1:0] K_ZERO = KW'(0);
  localparam logic [KW-1:0] K_ONE  = KW'(1);

  logic [BITS-1:0] a_r;
  logic [W-1:0]    b_r;
  logic [W-1:0]    n_r;
  logic [W-1:0]    p_r;
  logic [KW-1:0]   k_r;
  logic            run_r;
  logic            done_r;

  logic [W-1:0] dbl_s;
  logic [W-1:0] red_s;
  logic [W-1:0] add_s;
  logic [W-1:0] nxt_s;

  // One reduction step; p and b stay below n, so W = BITS+2 never overflows.
  always_comb begin
    dbl_s = p_r << 1;
    if (dbl_s >= n_r) begin
      red_s = dbl_s - n_r;
    end else begin
      red_s = dbl_s;
    end
    if (a_r[k_r]) begin
      add_s = red_s + b_r;
    end else begin
      add_s = red_s;
    end
    if (add_s >= n_r) begin
      nxt_s = add_s - n_r;
    end else begin
      nxt_s = add_s;
    end
  end

  // Operand capture, step sequencing and done flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r    <= {BITS{1'b0}};
      b_r    <= {W{1'b0}};
      n_r    <= {W{1'b0}};
      p_r    <= {W{1'b0}};
      k_r    <= K_ZERO;
      run_r  <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      a_r    <= a;
      b_r    <= {2'b00, b};
      n_r    <= {2'b00, n};
      p_r    <= {W{1'b0}};
      k_r    <= K_TOP;
      run_r  <= 1'b1;
      done_r <= 1'b0;
    end else if (run_r) begin
      p_r <= nxt_s;
      if (k_r == K_ZERO) begin
        run_r  <= 1'b0;
        done_r <= 1'b1;
      end else begin
        k_r    <= k_r - K_ONE;
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign p    = p_r[BITS-1:0];
  assign done = done_r;

endmodule

// File: rtl/rsa_modexp_engine.sv
// Left-to-right square-and-multiply controller computing r = m^e mod n,
// using rsa_modmul for every square and multiply.
module rsa_modexp_engine
  import rsa_modexp_engine_pkg::*;
#(
  parameter int BITS = BITS_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            go,
  input  logic [BITS-1:0] m,
  input  logic [BITS-1:0] e,
  input  logic [BITS-1:0] n,
  output logic [BITS-1:0] r,
  output logic            d,
  output logic            busy,
  output logic            err
);

  localparam int KW = $clog2(BITS);
  localparam logic [KW-1:0] I_TOP  = KW'(BITS - 1);
  localparam logic [KW-1:0] I_ZERO = KW'(0);
  localparam logic [KW-1:0] I_ONE  = KW'(1);
  localparam logic [BITS-1:0] V_ZERO = {BITS{1'b0}};
  localparam logic [BITS-1:0] V_ONE  = BITS'(1);
  localparam logic [BITS-1:0] V_TWO  = BITS'(2);

  logic [2:0]      state_r;
  logic            go_q_r;
  logic [BITS-1:0] m_r;
  logic [BITS-1:0] e_r;
  logic [BITS-1:0] n_r;
  logic [BITS-1:0] acc_r;
  logic [KW-1:0]   i_r;
  logic            bad_r;
  logic            mm_start_r;
  logic [BITS-1:0] r_r;
  logic            d_r;
  logic            busy_r;
  logic            err_r;

  logic            start_s;
  logic [BITS-1:0] mm_b_s;
  logic [BITS-1:0] mm_p_s;
  logic            mm_done_s;

  assign start_s = go & ~go_q_r & ((state_r == ST_IDLE) | (state_r == ST_FIN));
  assign mm_b_s  = (state_r == ST_MUL) ? m_r : acc_r;

  rsa_modmul #(.BITS(BITS)) u_modmul (
    .clk   (clk),
    .reset (reset),
    .start (mm_start_r),
    .a     (acc_r),
    .b     (mm_b_s),
    .n     (n_r),
    .p     (mm_p_s),
    .done  (mm_done_s)
  );

  // Controller FSM, exponent index, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      go_q_r     <= 1'b0;
      m_r        <= V_ZERO;
      e_r        <= V_ZERO;
      n_r        <= V_ZERO;
      acc_r      <= V_ZERO;
      i_r        <= I_ZERO;
      bad_r      <= 1'b0;
      mm_start_r <= 1'b0;
      r_r        <= V_ZERO;
      d_r        <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      go_q_r     <= go;
      mm_start_r <= 1'b0;
      if (start_s) begin
        m_r     <= m;
        e_r     <= e;
        n_r     <= n;
        d_r     <= 1'b0;
        err_r   <= 1'b0;
        busy_r  <= 1'b1;
        state_r <= ST_CHECK;
      end else begin
        case (state_r)
          ST_CHECK: begin
            if ((n_r < V_TWO) || (m_r >= n_r)) begin
              acc_r   <= V_ZERO;
              bad_r   <= 1'b1;
              state_r <= ST_FIN;
            end else if (e_r == V_ZERO) begin
              acc_r   <= V_ONE;
              bad_r   <= 1'b0;
              state_r <= ST_FIN;
            end else begin
              i_r     <= I_TOP;
              bad_r   <= 1'b0;
              state_r <= ST_SCAN;
            end
          end
          ST_SCAN: begin
            if (e_r[i_r]) begin
              acc_r <= m_r;
              if (i_r == I_ZERO) begin
                state_r <= ST_FIN;
              end else begin
                i_r        <= i_r - I_ONE;
                mm_start_r <= 1'b1;
                state_r    <= ST_SQR;
              end
            end else begin
              i_r <= i_r - I_ONE;
            end
          end
          ST_SQR: begin
            if (mm_done_s) begin
              acc_r <= mm_p_s;
              if (e_r[i_r]) begin
                mm_start_r <= 1'b1;
                state_r    <= ST_MUL;
              end else if (i_r == I_ZERO) begin
                state_r <= ST_FIN;
              end else begin
                i_r        <= i_r - I_ONE;
                mm_start_r <= 1'b1;
              end
            end
          end
          ST_MUL: begin
            if (mm_done_s) begin
              acc_r <= mm_p_s;
              if (i_r == I_ZERO) begin
                state_r <= ST_FIN;
              end else begin
                i_r        <= i_r - I_ONE;
                mm_start_r <= 1'b1;
                state_r    <= ST_SQR;
              end
            end
          end
          ST_FIN: begin
            r_r    <= acc_r;
            d_r    <= 1'b1;
            busy_r <= 1'b0;
            err_r  <= bad_r;
          end
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign r    = r_r;
  assign d    = d_r;
  assign busy = busy_r;
  assign err  = err_r;

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Self-checking bench for rsa_modexp_engine: scoreboarded directed and random
// operations checked for result, error flag and exact latency.
module tb_rsa_modexp_engine;

  localparam int BITS = 32;

  logic            clk;
  logic            reset;
  logic            go;
  logic [BITS-1:0] m;
  logic [BITS-1:0] e;
  logic [BITS-1:0] n;
  logic [BITS-1:0] r;
  logic            d;
  logic            busy;
  logic            err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [BITS-1:0] r;
    logic            err;
    int              lat;
  } exp_t;

  exp_t sb[$];

  rsa_modexp_engine #(.BITS(BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .go    (go),
    .m     (m),
    .e     (e),
    .n     (n),
    .r     (r),
    .d     (d),
    .busy  (busy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: 64-bit products reduced with %, independent of the shift-add datapath.
  function automatic exp_t model(input logic [31:0] mi, input logic [31:0] ei, input logic [31:0] ni);
    exp_t x;
    logic [63:0] acc;
    logic [63:0] n64;
    logic [63:0] m64;
    int j;
    int w;
    n64 = {32'd0, ni};
    m64 = {32'd0, mi};
    j = -1;
    w = 0;
    for (int k = 0; k < 32; k++) begin
      if (ei[k]) begin
        j = k;
        w++;
      end
    end
    if ((ni < 32'd2) || (mi >= ni)) begin
      x.r = 32'd0; x.err = 1'b1; x.lat = 2;
    end else if (ei == 32'd0) begin
      x.r = 32'd1; x.err = 1'b0; x.lat = 2;
    end else begin
      acc = 64'd1;
      for (int k = 31; k >= 0; k--) begin
        acc = (acc * acc) % n64;
        if (ei[k]) acc = (acc * m64) % n64;
      end
      x.r = acc[31:0];
      x.err = 1'b0;
      x.lat = 3 + (BITS - 1 - j) + (j + w - 1) * (BITS + 2);
    end
    return x;
  endfunction

  // Launch one operation, optionally pulsing go again (with junk operands) while busy.
  task automatic run_op(input string tag, input logic [31:0] mi, input logic [31:0] ei,
                        input logic [31:0] ni, input int glitch_at);
    exp_t x;
    int lat;
    bit seen;
    sb.push_back(model(mi, ei, ni));
    @(negedge clk);
    m = mi; e = ei; n = ni; go = 1'b1;
    @(posedge clk); #1;
    check({tag, ".busy"}, busy, 1'b1);
    check({tag, ".d_clr"}, d, 1'b0);
    lat = 0;
    seen = 1'b0;
    for (int c = 0; c < 6000 && !seen; c++) begin
      @(negedge clk);
      if (glitch_at > 0 && c == glitch_at) begin
        go = 1'b1; m = 32'd0; e = 32'd0;
      end else begin
        go = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (d) seen = 1'b1;
    end
    check({tag, ".done_seen"}, seen, 1'b1);
    x = sb.pop_front();
    check({tag, ".r"}, r, x.r);
    check({tag, ".err"}, err, x.err);
    check({tag, ".lat"}, lat, x.lat);
    check({tag, ".busy_off"}, busy, 1'b0);
  endtask

  initial begin
    exp_t x;
    int rises;
    logic prev_d;
    logic [31:0] rm;
    logic [31:0] re;
    logic [31:0] rn;

    reset = 1'b1; go = 1'b0; m = 32'd0; e = 32'd0; n = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.r", r, 32'd0);
    check("rst.d", d, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.err", err, 1'b0);
    @(negedge clk); reset = 1'b0;

    check("t1.const", model(32'd4, 32'd13, 32'd497).r, 32'd445);
    run_op("t1", 32'd4, 32'd13, 32'd497, 0);
    check("t1.lat_const", model(32'd4, 32'd13, 32'd497).lat, 201);
    run_op("enc", 32'd65, 32'd17, 32'd3233, 0);
    check("enc.r_const", r, 32'd2790);
    run_op("dec", 32'd2790, 32'd413, 32'd3233, 0);
    check("dec.r_const", r, 32'd65);

    run_op("e0", 32'd7, 32'd0, 32'd3233, 0);
    run_op("n1", 32'd0, 32'd5, 32'd1, 0);
    run_op("m_eq_n", 32'd3233, 32'd5, 32'd3233, 0);
    run_op("wide", 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF, 0);
    run_op("m0", 32'd0, 32'd9, 32'd3233, 0);
    run_op("m1", 32'd1, 32'hF0F0_F0F1, 32'd3233, 0);
    run_op("e1", 32'd1234, 32'd1, 32'd3233, 0);
    run_op("nmax", 32'h8765_4321, 32'h8000_0003, 32'hFFFF_FFFF, 0);

    for (int t = 0; t < 5; t++) begin
      rn = $urandom;
      if (rn < 32'd2) rn = rn + 32'd2;
      rm = $urandom % rn;
      re = $urandom;
      run_op("rand", rm, re, rn, 0);
    end

    // Level go held high: exactly one computation.
    x = model(32'd5, 32'd3, 32'd97);
    sb.push_back(x);
    @(negedge clk);
    m = 32'd5; e = 32'd3; n = 32'd97; go = 1'b1;
    rises = 0;
    prev_d = d;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      if (d && !prev_d) rises++;
      prev_d = d;
    end
    x = sb.pop_front();
    check("hold.rises", rises, 1);
    check("hold.r", r, x.r);
    check("hold.busy", busy, 1'b0);
    @(negedge clk); go = 1'b0;
    @(posedge clk);

    run_op("glitch", 32'd65, 32'd17, 32'd3233, 30);

    // Reset mid-operation aborts cleanly.
    @(negedge clk);
    m = 32'd4; e = 32'd13; n = 32'd497; go = 1'b1;
    @(posedge clk);
    @(negedge clk); go = 1'b0;
    repeat (49) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("abort.d", d, 1'b0);
    check("abort.r", r, 32'd0);
    check("abort.busy", busy, 1'b0);
    @(negedge clk); reset = 1'b0;
    run_op("after_abort", 32'd65, 32'd17, 32'd3233, 0);

    // go edge coincident with reset: reset wins.
    @(negedge clk); reset = 1'b1; go = 1'b1;
    @(posedge clk); #1;
    check("rstgo.busy", busy, 1'b0);
    check("rstgo.d", d, 1'b0);
    @(negedge clk); go = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    check("rstgo.idle", busy, 1'b0);
    run_op("final", 32'd3, 32'd200, 32'd1000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
